// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   launch an op; honoured only in IDLE
//   funct3  in   RV32M op select (MUL..REMU)
//   op_a    in   rs1 operand
//   op_b    in   rs2 operand
//   flush   in   abort any in-flight op, highest priority after reset
//   busy    out  high while iterating
//   done    out  one-cycle pulse, result valid
//   result  out  last completed result, held until the next done

module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_funct3;
    logic              r_neg;
    logic [XLEN-1:0]   r_b;
    // Multiply: hi = running partial sum, lo = multiplier shifting out.
    // Divide:   hi = partial remainder,   lo = dividend shifting out / quotient shifting in.
    logic [2*XLEN-1:0] r_prod;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    // Operand conditioning at capture time
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_neg_cap;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic [XLEN-1:0]   w_special;

    // One iteration step
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_fits;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_next;

    // Final sign fix-up
    logic [2*XLEN-1:0] w_mul_fix;
    logic [XLEN-1:0]   w_div_val;
    logic [XLEN-1:0]   w_div_fix;
    logic [XLEN-1:0]   w_final;

    // DIV/REM: both signed. MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned.
    assign w_a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign w_b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign w_a_neg    = w_a_signed & op_a[XLEN-1];
    assign w_b_neg    = w_b_signed & op_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -op_a : op_a;
    assign w_b_mag    = w_b_neg ? -op_b : op_b;
    // Remainder takes the dividend's sign; quotient and product take sign(a)^sign(b).
    assign w_neg_cap  = (funct3[2] & funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div_zero = funct3[2] & (op_b == '0);
    assign w_div_ovf  = funct3[2] & ~funct3[0] & (op_a == MIN_VAL) & (op_b == '1);
    assign w_special  = w_div_zero ? (funct3[1] ? op_a : '1)
                                   : (funct3[1] ? '0 : op_a);

    assign w_hi = r_prod[2*XLEN-1:XLEN];
    assign w_lo = r_prod[XLEN-1:0];

    // Shift-add: conditionally add multiplicand to the top half, then shift the whole pair right.
    assign w_sum      = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_sum, w_lo[XLEN-1:1]};

    // Restoring divide: bring in the next dividend bit, subtract if it fits.
    assign w_shift    = {w_hi, w_lo[XLEN-1]};
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_fits     = ~w_diff[XLEN];
    assign w_div_next = {(w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0]),
                         w_lo[XLEN-2:0], w_fits};

    assign w_next = r_funct3[2] ? w_div_next : w_mul_next;

    // Product negation spans the full double-width value so MULH* high halves are correct.
    assign w_mul_fix = r_neg ? -w_next : w_next;
    assign w_div_val = r_funct3[1] ? w_next[2*XLEN-1:XLEN] : w_next[XLEN-1:0];
    assign w_div_fix = r_neg ? -w_div_val : w_div_val;
    assign w_final   = r_funct3[2]             ? w_div_fix :
                       (r_funct3[1:0] == 2'b00) ? w_mul_fix[XLEN-1:0] :
                                                  w_mul_fix[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_neg    <= 1'b0;
            r_b      <= '0;
            r_prod   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_funct3 <= funct3;
                        r_neg    <= w_neg_cap;
                        if (w_div_zero || w_div_ovf) begin
                            r_result <= w_special;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_cnt   <= CW'(XLEN - 1);
                            r_busy  <= 1'b1;
                            r_state <= S_CALC;
                            // Divide: dividend in lo, divisor held. Multiply: multiplier in lo.
                            r_b     <= funct3[2] ? w_b_mag : w_a_mag;
                            r_prod  <= {{XLEN{1'b0}}, (funct3[2] ? w_a_mag : w_b_mag)};
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_prod <= w_next;
                        r_cnt  <= r_cnt - CW'(1);
                        if (r_cnt == '0) begin
                            r_result <= w_final;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit

module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          sp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          ua;
        longint          ub;
        longint          p;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = longint'(ua) * longint'(ub); return up[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Launch one op at edge N and watch edges N..N+XLEN+2.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit sp);
        int          done_at;
        int          busy_bad;
        int          exp_done;
        logic [31:0] res;
        done_at  = -1;
        busy_bad = 0;
        res      = 'x;
        exp_done = sp ? 0 : XLEN;
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i <= XLEN + 2; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy !== (!sp && i < XLEN)) busy_bad++;
            if (done === 1'b1) begin
                if (done_at < 0) begin
                    done_at = i;
                    res = result;
                end else begin
                    done_at = 1000;
                end
            end
        end
        chk({name, "_done_cycle"}, 32'(done_at), 32'(exp_done));
        chk({name, "_busy_pattern"}, 32'(busy_bad), 32'd0);
        chk({name, "_result"}, res, exp);
    endtask

    vec_t vecs[14];

    initial begin
        logic [31:0] held;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          done_at;
        int          bad;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        1'b0};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         1'b0};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{3'd6, 32'h8000_0000,  32'd0,         32'h8000_0000, 1'b1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[12] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[13] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].sp);

        // Randomised ops against the model, biased toward corner operands
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: b = 32'($signed(-$urandom_range(1, 9)));
                default: ;
            endcase
            run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, model(f, a, b), is_special(f, a, b));
        end

        // Flush of a DIV at edge N+10: no done, busy low, result kept; new start at N+11
        held = result;
        @(negedge clk);
        funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_done", {31'b0, done}, 32'd0);
        chk("flush_result", result, held);
        run_op("after_flush", 3'd4, 32'hFFFF_FF00, 32'd16, model(3'd4, 32'hFFFF_FF00, 32'd16), 1'b0);

        // Flush with start in IDLE: even a special-case op must not launch
        @(negedge clk);
        funct3 = 3'd5; op_a = 32'd9; op_b = 32'd0; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        chk("idle_flush_done", {31'b0, done}, 32'd0);
        chk("idle_flush_busy", {31'b0, busy}, 32'd0);

        // start held high through CALC and DONE with operands churning
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd12345; op_b = 32'hFFFF_FF85; start = 1'b1;
        @(posedge clk);
        done_at = -1;
        held = 'x;
        for (int i = 0; i <= XLEN + 1; i++) begin
            if (i > 0) @(posedge clk);
            #1;
            op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom_range(0, 7));
            if (done === 1'b1 && done_at < 0) begin
                done_at = i;
                held = result;
            end
        end
        start = 1'b0;
        chk("held_start_done_cycle", 32'(done_at), 32'(XLEN));
        chk("held_start_result", held, model(3'd0, 32'd12345, 32'hFFFF_FF85));
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("held_start_no_relaunch", 32'(bad), 32'd0);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        funct3 = 3'd7; op_a = 32'd77; op_b = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_busy", {31'b0, busy}, 32'd0);
        chk("midreset_done", {31'b0, done}, 32'd0);
        chk("midreset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < XLEN + 4; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("midreset_no_done", 32'(bad), 32'd0);
        run_op("post_reset", 3'd6, 32'hFFFF_FF9C, 32'd7, model(3'd6, 32'hFFFF_FF9C, 32'd7), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
